prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader between an external 10-bit word stream and the CPU's 14-bit-address / 10-bit-data memory port. After reset it holds the CPU in reset. It receives one framed program image and writes it into memory starting at the CPU reset vector (0x2000). It then verifies a checksum and releases the CPU. Once the load completes, it becomes a transparent pass-through between the CPU memory port and the memory.

## Interface
Parameters:
- BASE_ADDR, 14'h2000, first memory word written; equals the CPU reset PC
- MAX_INSTR, 1023, largest accepted instruction count (each instruction is 3 words)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse; begins a new load from IDLE, DONE or ERR
- s_valid  in  1  stream word valid
- s_data  in  10  stream word
- s_ready  out  1  loader accepts s_data this cycle
- cpu_addr  in  14  CPU memory address
- cpu_wdata  in  10  CPU write data
- cpu_write  in  1  CPU write strobe
- cpu_read  in  1  CPU read strobe
- cpu_rdata  out  10  read data returned to CPU
- mem_addr  out  14  memory address
- mem_wdata  out  10  memory write data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rdata  in  10  memory read data
- cpu_rst  out  1  reset to CPU, active-high
- busy  out  1  load in progress (HDR/LOAD/CSUM)
- done  out  1  image loaded and verified
- error  out  1  load failed
- word_cnt  out  12  data words written in the current load

## Operation
- Frame format: header word N (instruction count, 1..MAX_INSTR), then 3N data words, then one checksum word. The checksum is the sum of the 3N data words mod 1024. The header is not included in the sum.
- States:
  - IDLE: no load yet.
  - HDR: waiting for the header word.
  - LOAD: writing data words.
  - CSUM: waiting for the checksum word.
  - DONE: image verified.
  - ERR: load failed.
- Transitions:
  - IDLE, DONE or ERR with start goes to HDR, and clears word_cnt and the running sum.
  - HDR on handshake: N=0 or N>MAX_INSTR goes to ERR; otherwise latch total = 3N and go to LOAD.
  - LOAD on handshake: write s_data to BASE_ADDR+word_cnt, add it to the sum, increment word_cnt. When the incremented word_cnt equals total, go to CSUM.
  - CSUM on handshake: if the word equals the sum, go to DONE; otherwise go to ERR.
- Handshake: a word transfers on a cycle where s_valid and s_ready are both 1. s_ready is 1 exactly in HDR, LOAD and CSUM. s_valid without s_ready is ignored.
- Memory mux:
  - In LOAD: mem_addr = BASE_ADDR+word_cnt, mem_wdata = s_data, mem_we = s_valid, mem_re = 0.
  - In DONE: mem_* = cpu_* pass-through, and cpu_rdata = mem_rdata.
  - In all other states: mem_we = mem_re = 0, mem_addr = 0, mem_wdata = 0, and cpu_rdata = 0. CPU strobes are ignored.
- cpu_rst = 1 in every state except DONE.
- start while busy is ignored.
- Width rules: BASE_ADDR+word_cnt is computed at 14 bits and cannot wrap, since the maximum address is 0x2BFC. The sum is 10 bits and wraps.

## Timing
- Reset values: state IDLE, cpu_rst 1, s_ready 0, busy 0, done 0, error 0, word_cnt 0, all mem_* 0, cpu_rdata 0.
- State, word_cnt and sum update on the clk edge of the handshake. The status outputs (busy, done, error) and cpu_rst are decoded from the registered state.
- Memory write has zero latency. mem_we is asserted in the same cycle as the LOAD handshake, and the memory captures the word on that edge.
- start accepted at edge k: s_ready is 1 from cycle k+1.
- Checksum accepted at edge k: done = 1 and cpu_rst = 0 from cycle k+1, and the CPU sees its first fetch cycle after that edge.
- Pass-through in DONE is purely combinational, so it adds no cycles to CPU memory access.
- rst mid-load: on the next edge return to IDLE with cpu_rst = 1. Memory already written is not cleared.
- start in DONE: cpu_rst reasserts the following cycle and a fresh load begins.

## Structure
- Shared package loader_pkg holds:
  - the state enum loader_state_t with members IDLE, HDR, LOAD, CSUM, DONE and ERR
  - constants LD_BASE_ADDR = 14'h2000 and LD_WORDS_PER_INSTR = 3
- A single module with no sub-modules. The mux and the FSM are small enough that splitting them adds nothing.

## Test plan
- Load N=1 with data 0x001, 0x002, 0x003 and checksum 0x006 -> memory 0x2000..0x2002 = 1,2,3; done=1; cpu_rst falls the cycle after the checksum handshake; word_cnt=3.
- Same frame with checksum 0x007 -> error=1, cpu_rst stays 1, done=0.
- Header 0x000 -> ERR immediately; no mem_we pulse is ever seen.
- N=2 with s_valid toggling every other cycle and data 0x3FF ×6 (sum wraps to 0x3FA) -> writes land at 0x2000..0x2005 only on handshake cycles; done.
- After done, CPU writes 0x155 to 0x0010 and then reads 0x0010 -> mem_* mirror cpu_*, and cpu_rdata = 0x155 in the same cycle.
- rst asserted after 2 LOAD words -> next cycle state IDLE, cpu_rst=1, word_cnt=0. A new start plus a full frame then loads successfully.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Imported by prog_loader and its testbench.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  localparam logic [13:0] LD_BASE_ADDR       = 14'h2000;
  localparam int unsigned LD_WORDS_PER_INSTR = 3;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: receives a framed image over a word stream and writes it at the reset vector,
// verifies the checksum, then releases the CPU and passes its memory port straight through.
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR = LD_BASE_ADDR,
  parameter int unsigned MAX_INSTR = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [9:0]  s_data,
  output logic        s_ready,
  input  logic [13:0] cpu_addr,
  input  logic [9:0]  cpu_wdata,
  input  logic        cpu_write,
  input  logic        cpu_read,
  output logic [9:0]  cpu_rdata,
  output logic [13:0] mem_addr,
  output logic [9:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [9:0]  mem_rdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [11:0] word_cnt
);

  loader_state_t state_q, state_d;
  logic [11:0]   word_cnt_q, word_cnt_d;
  logic [11:0]   total_q, total_d;
  logic [9:0]    sum_q, sum_d;

  logic          hs;
  logic          hdr_bad;
  logic [11:0]   cnt_inc;
  logic          can_start;

  // s_ready is a pure decode of state, so it is safe to use here without a loop.
  assign hs        = s_valid & s_ready;
  assign hdr_bad   = (s_data == 10'd0) || (32'(s_data) > MAX_INSTR);
  assign cnt_inc   = word_cnt_q + 12'd1;
  assign can_start = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        if (hs) state_d = hdr_bad ? ERR : LOAD;
      end
      LOAD: begin
        if (hs && (cnt_inc == total_q)) state_d = CSUM;
      end
      CSUM: begin
        if (hs) state_d = (s_data == sum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: word counter, running sum, expected word total
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= 12'd0;
      total_q    <= 12'd0;
      sum_q      <= 10'd0;
    end else begin
      word_cnt_q <= word_cnt_d;
      total_q    <= total_d;
      sum_q      <= sum_d;
    end
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    total_d    = total_q;
    sum_d      = sum_q;
    if (can_start) begin
      word_cnt_d = 12'd0;
      sum_d      = 10'd0;
    end else if (hs && (state_q == HDR) && !hdr_bad) begin
      total_d = 12'(s_data) * 12'(LD_WORDS_PER_INSTR);
    end else if (hs && (state_q == LOAD)) begin
      word_cnt_d = cnt_inc;
      sum_d      = sum_q + s_data;
    end
  end

  // Output decode and memory port mux
  always_comb begin
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_rst   = 1'b1;
    mem_addr  = 14'd0;
    mem_wdata = 10'd0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    cpu_rdata = 10'd0;
    case (state_q)
      HDR, CSUM: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      LOAD: begin
        s_ready   = 1'b1;
        busy      = 1'b1;
        // Highest address is BASE_ADDR + 3*MAX_INSTR - 1, well inside 14 bits.
        mem_addr  = BASE_ADDR + 14'(word_cnt_q);
        mem_wdata = s_data;
        mem_we    = s_valid;
      end
      DONE: begin
        done      = 1'b1;
        cpu_rst   = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_write;
        mem_re    = cpu_read;
        cpu_rdata = mem_rdata;
      end
      ERR: begin
        error = 1'b1;
      end
      default: ;
    endcase
  end

  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and randomized frames checked against
// a frame-level model of the loader rules and a behavioural memory.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int unsigned TbMaxInstr = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic [9:0]  s_data;
  logic        s_ready;
  logic [13:0] cpu_addr;
  logic [9:0]  cpu_wdata;
  logic        cpu_write;
  logic        cpu_read;
  logic [9:0]  cpu_rdata;
  logic [13:0] mem_addr;
  logic [9:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [9:0]  mem_rdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] word_cnt;

  prog_loader #(
    .BASE_ADDR (LD_BASE_ADDR),
    .MAX_INSTR (TbMaxInstr)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_write (cpu_write),
    .cpu_read  (cpu_read),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: write captured on the edge, read combinational.
  logic [9:0] tb_mem [16384];
  int         we_pulses = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      we_pulses++;
    end
  end
  assign mem_rdata = tb_mem[mem_addr];

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [9:0] fd [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one word (optionally after an idle cycle) and check the memory port during it.
  task automatic send_word(input logic [9:0] w, input bit gap, input bit is_load,
                           input logic [13:0] addr);
    if (gap) begin
      s_valid = 1'b0;
      s_data  = 10'($urandom);
      #1;
      check("idle_no_we", 32'(mem_we), 32'd0);
      step();
    end
    s_valid = 1'b1;
    s_data  = w;
    #1;
    check("s_ready", 32'(s_ready), 32'd1);
    if (is_load) begin
      check("load_we", 32'(mem_we), 32'd1);
      check("load_addr", 32'(mem_addr), 32'(addr));
      check("load_wdata", 32'(mem_wdata), 32'(w));
    end else begin
      check("no_we", 32'(mem_we), 32'd0);
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("start_s_ready", 32'(s_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_cnt", 32'(word_cnt), 32'd0);
    check("start_cpu_rst", 32'(cpu_rst), 32'd1);
    check("start_done", 32'(done), 32'd0);
  endtask

  // Whole frame: header n_hdr, 3*n_hdr words from fd[], then csum.
  task automatic send_frame(input int unsigned n_hdr, input logic [9:0] csum, input bit gaps,
                            input bit start_noise);
    int unsigned nwords;
    int unsigned sum;
    bit          hdr_ok;
    bit          exp_ok;
    hdr_ok = (n_hdr >= 1) && (n_hdr <= TbMaxInstr);
    nwords = hdr_ok ? 3 * n_hdr : 0;
    sum    = 0;
    for (int i = 0; i < int'(nwords); i++) sum += fd[i];
    exp_ok = hdr_ok && (csum == 10'(sum % 1024));

    pulse_start();
    send_word(10'(n_hdr), gaps, 1'b0, 14'd0);
    #1;
    if (!hdr_ok) begin
      check("hdr_err", 32'(error), 32'd1);
      check("hdr_err_busy", 32'(busy), 32'd0);
      check("hdr_err_ready", 32'(s_ready), 32'd0);
      check("hdr_err_cpu_rst", 32'(cpu_rst), 32'd1);
      return;
    end
    for (int i = 0; i < int'(nwords); i++) begin
      send_word(fd[i], gaps && ($urandom_range(0, 1) == 1), 1'b1, LD_BASE_ADDR + 14'(i));
      #1;
      check("word_cnt", 32'(word_cnt), 32'(i + 1));
      if (start_noise && i == 0) begin
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        check("busy_start_busy", 32'(busy), 32'd1);
        check("busy_start_cnt", 32'(word_cnt), 32'd1);
      end
    end
    check("pre_csum_cpu_rst", 32'(cpu_rst), 32'd1);
    check("pre_csum_done", 32'(done), 32'd0);
    send_word(csum, gaps, 1'b0, 14'd0);
    #1;
    check("end_done", 32'(done), 32'(exp_ok));
    check("end_error", 32'(error), 32'(!exp_ok));
    check("end_cpu_rst", 32'(cpu_rst), 32'(!exp_ok));
    check("end_busy", 32'(busy), 32'd0);
    check("end_cnt", 32'(word_cnt), 32'(nwords));
    for (int i = 0; i < int'(nwords); i++) begin
      check("mem_image", 32'(tb_mem[LD_BASE_ADDR + 14'(i)]), 32'(fd[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w0;
    int unsigned n;
    int unsigned sum;
    logic [9:0]  cs;

    rst       = 1'b1;
    start     = 1'b0;
    s_valid   = 1'b0;
    s_data    = 10'd0;
    cpu_addr  = 14'h0123;
    cpu_wdata = 10'h2AA;
    cpu_write = 1'b1;
    cpu_read  = 1'b1;
    @(negedge clk);
    step();
    #1;
    // Reset state, with CPU strobes active and ignored
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cnt", 32'(word_cnt), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    rst = 1'b0;
    step();

    // N=1, good checksum; CPU strobes still active and must stay blocked while loading
    fd[0] = 10'h001; fd[1] = 10'h002; fd[2] = 10'h003;
    send_frame(1, 10'h006, 1'b0, 1'b0);
    cpu_write = 1'b0;
    cpu_read  = 1'b0;

    // Same frame, bad checksum
    send_frame(1, 10'h007, 1'b0, 1'b0);

    // Header zero: no memory writes at all
    w0 = we_pulses;
    send_frame(0, 10'h000, 1'b0, 1'b0);
    step();
    check("hdr0_no_we", 32'(we_pulses), 32'(w0));

    // N=2, all 0x3FF with gaps, sum wraps to 0x3FA; start while busy ignored
    for (int i = 0; i < 6; i++) fd[i] = 10'h3FF;
    send_frame(2, 10'h3FA, 1'b1, 1'b1);

    // Pass-through after done
    cpu_addr  = 14'h0010;
    cpu_wdata = 10'h155;
    cpu_write = 1'b1;
    #1;
    check("pt_addr", 32'(mem_addr), 32'h0010);
    check("pt_wdata", 32'(mem_wdata), 32'h155);
    check("pt_we", 32'(mem_we), 32'd1);
    check("pt_re_low", 32'(mem_re), 32'd0);
    step();
    cpu_write = 1'b0;
    cpu_read  = 1'b1;
    #1;
    check("pt_re", 32'(mem_re), 32'd1);
    check("pt_we_low", 32'(mem_we), 32'd0);
    check("pt_rdata", 32'(cpu_rdata), 32'h155);
    cpu_read = 1'b0;

    // Header bounds: one over the limit fails, the limit itself loads
    send_frame(TbMaxInstr + 1, 10'h000, 1'b0, 1'b0);
    sum = 0;
    for (int i = 0; i < int'(3 * TbMaxInstr); i++) begin
      fd[i] = 10'($urandom);
      sum += fd[i];
    end
    send_frame(TbMaxInstr, 10'(sum % 1024), 1'b0, 1'b0);

    // Reset after two LOAD words
    fd[0] = 10'h111; fd[1] = 10'h222;
    pulse_start();
    send_word(10'd2, 1'b0, 1'b0, 14'd0);
    send_word(fd[0], 1'b0, 1'b1, LD_BASE_ADDR);
    send_word(fd[1], 1'b0, 1'b1, LD_BASE_ADDR + 14'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(s_ready), 32'd0);
    check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("mid_rst_cnt", 32'(word_cnt), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_mem_kept", 32'(tb_mem[LD_BASE_ADDR + 14'd1]), 32'h222);
    sum = 0;
    for (int i = 0; i < 6; i++) begin
      fd[i] = 10'($urandom);
      sum += fd[i];
    end
    send_frame(2, 10'(sum % 1024), 1'b0, 1'b0);

    // Random frames, some with corrupted checksums
    for (int k = 0; k < 8; k++) begin
      n   = $urandom_range(1, 4);
      sum = 0;
      for (int i = 0; i < int'(3 * n); i++) begin
        fd[i] = 10'($urandom);
        sum += fd[i];
      end
      cs = 10'(sum % 1024);
      if ($urandom_range(0, 2) == 0) cs = cs ^ 10'($urandom_range(1, 1023));
      send_frame(n, cs, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
